// File: rtl/dffram_2r1w_ctrl.sv
// dffram_2r1w_ctrl: client-side controller for a 256x16 2R1W DFFRAM macro.
// Port 0 is shared between the write channel and read channel A.
// Port 1 serves read channel B only.
// Read responses have one-cycle latency and are held under back-pressure.
// Optional feature macro: DFFRAM_CTRL_BYPASS_EN. When defined, a same-cycle
// write and read B to the same address forward the written byte lanes into
// the read-B response.
module dffram_2r1w_ctrl #(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int WSIZE = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic [WSIZE-1:0] wr_be,
  input  logic             rda_valid,
  output logic             rda_ready,
  input  logic [AW-1:0]    rda_addr,
  output logic             rda_rvalid,
  input  logic             rda_rready,
  output logic [DW-1:0]    rda_rdata,
  input  logic             rdb_valid,
  output logic             rdb_ready,
  input  logic [AW-1:0]    rdb_addr,
  output logic             rdb_rvalid,
  input  logic             rdb_rready,
  output logic [DW-1:0]    rdb_rdata,
  output logic             ram_EN0,
  output logic             ram_EN1,
  output logic [WSIZE-1:0] ram_WE0,
  output logic [AW-1:0]    ram_A0,
  output logic [AW-1:0]    ram_A1,
  output logic [DW-1:0]    ram_Di0,
  input  logic [DW-1:0]    ram_Do0,
  input  logic [DW-1:0]    ram_Do1
);

  logic          pri_reg;
  logic          a_rvalid_reg, a_first_reg;
  logic [DW-1:0] a_hold_reg;
  logic          b_rvalid_reg, b_first_reg;
  logic [DW-1:0] b_hold_reg;
  logic [DW-1:0] b_fresh;
  logic          a_req, contend;
  logic          grant_w, grant_a, grant_b;

  // Arbitration: eligibility from response-slot state, port 0 settled by pri.
  // Everything is forced idle while reset is asserted.
  always_comb begin
    a_req   = rda_valid && (!a_rvalid_reg || rda_rready);
    contend = wr_valid && a_req;
    grant_w = 1'b0;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (RST_N) begin
      grant_w = wr_valid && (!a_req || !pri_reg);
      grant_a = a_req && (!wr_valid || pri_reg);
      grant_b = rdb_valid && (!b_rvalid_reg || rdb_rready);
    end
  end

  assign wr_ready  = grant_w;
  assign rda_ready = grant_a;
  assign rdb_ready = grant_b;

  // Macro port drive: granted request fields, zeros otherwise.
  always_comb begin
    ram_EN0 = 1'b0;
    ram_WE0 = '0;
    ram_A0  = '0;
    ram_Di0 = '0;
    ram_EN1 = grant_b;
    ram_A1  = grant_b ? rdb_addr : '0;
    if (grant_w) begin
      ram_EN0 = 1'b1;
      ram_WE0 = wr_be;
      ram_A0  = wr_addr;
      ram_Di0 = wr_data;
    end else if (grant_a) begin
      ram_EN0 = 1'b1;
      ram_A0  = rda_addr;
    end
  end

  // Priority flag flips after every contended grant so the loser wins next.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pri_reg <= 1'b0;
    end else if (contend) begin
      pri_reg <= !pri_reg;
    end
  end

  // Read-A response slot: first cycle passes ram_Do0 through, then holds.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_rvalid_reg <= 1'b0;
      a_first_reg  <= 1'b0;
      a_hold_reg   <= '0;
    end else begin
      if (grant_a) begin
        a_rvalid_reg <= 1'b1;
        a_first_reg  <= 1'b1;
      end else begin
        a_first_reg <= 1'b0;
        if (rda_rready) a_rvalid_reg <= 1'b0;
      end
      if (a_first_reg) a_hold_reg <= ram_Do0;
    end
  end

  assign rda_rvalid = a_rvalid_reg;
  assign rda_rdata  = a_first_reg ? ram_Do0 : a_hold_reg;

`ifdef DFFRAM_CTRL_BYPASS_EN
  logic [WSIZE-1:0] byp_mask_reg;
  logic [DW-1:0]    byp_data_reg;

  // Capture forwarding lanes when a write and read B hit the same word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      byp_mask_reg <= '0;
      byp_data_reg <= '0;
    end else if (grant_b) begin
      byp_mask_reg <= (grant_w && (wr_addr == rdb_addr)) ? wr_be : '0;
      byp_data_reg <= wr_data;
    end
  end

  for (genvar gi = 0; gi < WSIZE; gi++) begin : g_merge
    assign b_fresh[gi*8 +: 8] = byp_mask_reg[gi] ? byp_data_reg[gi*8 +: 8]
                                                 : ram_Do1[gi*8 +: 8];
  end
`else
  assign b_fresh = ram_Do1;
`endif

  // Read-B response slot: same scheme as A, sourced from the (merged) port 1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      b_rvalid_reg <= 1'b0;
      b_first_reg  <= 1'b0;
      b_hold_reg   <= '0;
    end else begin
      if (grant_b) begin
        b_rvalid_reg <= 1'b1;
        b_first_reg  <= 1'b1;
      end else begin
        b_first_reg <= 1'b0;
        if (rdb_rready) b_rvalid_reg <= 1'b0;
      end
      if (b_first_reg) b_hold_reg <= b_fresh;
    end
  end

  assign rdb_rvalid = b_rvalid_reg;
  assign rdb_rdata  = b_first_reg ? b_fresh : b_hold_reg;

endmodule

// File: tb/tb_dffram_2r1w_ctrl.sv
// tb_dffram_2r1w_ctrl: directed bench with a behavioural DFFRAM macro model
// and per-channel scoreboards of expected read data.
module tb_dffram_2r1w_ctrl;

  logic        clk;
  logic        RST_N;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rda_valid, rda_ready, rda_rvalid, rda_rready;
  logic [7:0]  rda_addr;
  logic [15:0] rda_rdata;
  logic        rdb_valid, rdb_ready, rdb_rvalid, rdb_rready;
  logic [7:0]  rdb_addr;
  logic [15:0] rdb_rdata;
  logic        ram_EN0, ram_EN1;
  logic [1:0]  ram_WE0;
  logic [7:0]  ram_A0, ram_A1;
  logic [15:0] ram_Di0, ram_Do0, ram_Do1;

  logic [15:0] ram_mem [256];
  logic [15:0] ref_mem [256];
  logic [15:0] qa [$];
  logic [15:0] qb [$];
  logic        exp_rv_a, exp_rv_b;
  int          checks, failures;

`ifdef DFFRAM_CTRL_BYPASS_EN
  localparam logic [15:0] BYP_EXP = 16'hCA11;
`else
  localparam logic [15:0] BYP_EXP = 16'h1111;
`endif

  dffram_2r1w_ctrl #(.AW(8), .DW(16), .WSIZE(2)) dut (
    .CLK(clk), .RST_N(RST_N),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be),
    .rda_valid(rda_valid), .rda_ready(rda_ready), .rda_addr(rda_addr),
    .rda_rvalid(rda_rvalid), .rda_rready(rda_rready), .rda_rdata(rda_rdata),
    .rdb_valid(rdb_valid), .rdb_ready(rdb_ready), .rdb_addr(rdb_addr),
    .rdb_rvalid(rdb_rvalid), .rdb_rready(rdb_rready), .rdb_rdata(rdb_rdata),
    .ram_EN0(ram_EN0), .ram_EN1(ram_EN1), .ram_WE0(ram_WE0),
    .ram_A0(ram_A0), .ram_A1(ram_A1), .ram_Di0(ram_Di0),
    .ram_Do0(ram_Do0), .ram_Do1(ram_Do1)
  );

  always #5 clk = ~clk;

  // Macro model: synchronous read on both ports, byte-lane write on port 0.
  always @(posedge clk) begin
    if (ram_EN0) begin
      if (ram_WE0 == 2'b00) ram_Do0 <= ram_mem[ram_A0];
      else for (int i = 0; i < 2; i++)
        if (ram_WE0[i]) ram_mem[ram_A0][i*8 +: 8] <= ram_Di0[i*8 +: 8];
    end
    if (ram_EN1) ram_Do1 <= ram_mem[ram_A1];
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_valid = 1'b0; rda_valid = 1'b0; rdb_valid = 1'b0;
  endtask

  // One clock cycle: score responses, record acceptances, advance to next negedge.
  task automatic cycle();
    logic aw, aa, ab;
    logic [15:0] e;
    aw = wr_valid && wr_ready;
    aa = rda_valid && rda_ready;
    ab = rdb_valid && rdb_ready;
    if (exp_rv_a) chk("rda_rvalid_latency", rda_rvalid, 1);
    if (exp_rv_b) chk("rdb_rvalid_latency", rdb_rvalid, 1);
    if (rda_rvalid && rda_rready) begin
      checks++;
      assert (qa.size() != 0) else begin
        failures++; $error("FAIL rda_spurious observed=rvalid expected=none");
      end
      if (qa.size() != 0) begin e = qa.pop_front(); chk("rda_rdata", rda_rdata, e); end
    end
    if (rdb_rvalid && rdb_rready) begin
      checks++;
      assert (qb.size() != 0) else begin
        failures++; $error("FAIL rdb_spurious observed=rvalid expected=none");
      end
      if (qb.size() != 0) begin e = qb.pop_front(); chk("rdb_rdata", rdb_rdata, e); end
    end
    if (ab) begin
      e = ref_mem[rdb_addr];
`ifdef DFFRAM_CTRL_BYPASS_EN
      if (aw && wr_addr == rdb_addr)
        for (int i = 0; i < 2; i++) if (wr_be[i]) e[i*8 +: 8] = wr_data[i*8 +: 8];
`endif
      qb.push_back(e);
    end
    if (aa) qa.push_back(ref_mem[rda_addr]);
    if (aw) for (int i = 0; i < 2; i++) if (wr_be[i]) ref_mem[wr_addr][i*8 +: 8] = wr_data[i*8 +: 8];
    $display("cycle t=%0t w=%0b a=%0b b=%0b rva=%0b rvb=%0b", $time, aw, aa, ab, rda_rvalid, rdb_rvalid);
    exp_rv_a = aa;
    exp_rv_b = ab;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    #1;
    chk("wr_ready", wr_ready, 1);
    cycle();
    wr_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] b2b_addr [3];
    b2b_addr = '{8'h05, 8'h12, 8'h20};
    clk = 1'b0; RST_N = 1'b0; checks = 0; failures = 0;
    exp_rv_a = 1'b0; exp_rv_b = 1'b0;
    wr_addr = '0; wr_data = '0; wr_be = '0; rda_addr = '0; rdb_addr = '0;
    rda_rready = 1'b0; rdb_rready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    wr_valid = 1'b1; rda_valid = 1'b1; rdb_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rda_rvalid", rda_rvalid, 0);
    chk("rst_rdb_rvalid", rdb_rvalid, 0);
    chk("rst_rda_rdata", rda_rdata, 0);
    chk("rst_rdb_rdata", rdb_rdata, 0);
    chk("rst_en", {ram_EN0, ram_EN1, ram_WE0}, 0);
    chk("rst_readys", {wr_ready, rda_ready, rdb_ready}, 0);
    idle();
    @(negedge clk);
    RST_N = 1'b1;

    // Preload and check port-0 drive on a granted write.
    wr_valid = 1'b1; wr_addr = 8'h05; wr_data = 16'h1234; wr_be = 2'b11;
    #1;
    chk("wr_port0", {ram_EN0, ram_WE0, ram_A0, ram_Di0}, {1'b1, 2'b11, 8'h05, 16'h1234});
    cycle();
    wr(8'h20, 16'h1111, 2'b11);
    wr(8'h12, 16'hBEEF, 2'b11);
    idle(); #1;
    chk("idle_port0", {ram_EN0, ram_WE0, ram_A0, ram_Di0, ram_EN1, ram_A1}, 0);
    cycle();

    // Write then read A.
    rda_valid = 1'b1; rda_addr = 8'h12; rda_rready = 1'b1; #1;
    chk("rda_ready", rda_ready, 1);
    cycle();
    idle(); #1;
    chk("rda_beef", rda_rdata, 16'hBEEF);
    cycle();

    // Byte-lane write then read B.
    wr(8'h12, 16'h00AA, 2'b01);
    rdb_valid = 1'b1; rdb_addr = 8'h12; rdb_rready = 1'b1; #1;
    cycle();
    idle(); #1;
    chk("rdb_bytelane", rdb_rdata, 16'hBEAA);
    cycle();

    // Contention: grants alternate write, A, write, A.
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 8'h30 + 8'(i); wr_data = 16'h3000 + 16'(i); wr_be = 2'b11;
      rda_valid = 1'b1; rda_addr = 8'h05; rda_rready = 1'b1; #1;
      chk("cont_wr_grant", wr_ready, (i % 2 == 0) ? 1 : 0);
      chk("cont_rda_grant", rda_ready, (i % 2 == 1) ? 1 : 0);
      cycle();
    end
    idle(); #1; cycle();

    // Back-pressure on read A with concurrent writes to the same word.
    rda_valid = 1'b1; rda_addr = 8'h05; rda_rready = 1'b0; #1;
    chk("bp_accept", rda_ready, 1);
    cycle();
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1; wr_addr = 8'h05; wr_data = 16'h5555; wr_be = 2'b11; #1;
      chk("bp_rvalid", rda_rvalid, 1);
      chk("bp_rdata", rda_rdata, 16'h1234);
      chk("bp_rda_ready", rda_ready, 0);
      chk("bp_wr_ready", wr_ready, 1);
      cycle();
    end
    idle(); rda_rready = 1'b1; #1;
    cycle();

    // Same-cycle write and read B to one address.
    wr_valid = 1'b1; wr_addr = 8'h20; wr_data = 16'hCAFE; wr_be = 2'b10;
    rdb_valid = 1'b1; rdb_addr = 8'h20; rdb_rready = 1'b1; #1;
    chk("byp_rdb_ready", rdb_ready, 1);
    cycle();
    idle(); #1;
    chk("bypass", rdb_rdata, BYP_EXP);
    cycle();

    // Back-to-back read B, one per cycle.
    for (int k = 0; k < 3; k++) begin
      rdb_valid = 1'b1; rdb_addr = b2b_addr[k]; #1;
      chk("b2b_rdb_ready", rdb_ready, 1);
      cycle();
    end
    idle();

    // Contended grant to the write sets pri, then reset mid-burst.
    wr_valid = 1'b1; wr_addr = 8'h40; wr_data = 16'h4040; wr_be = 2'b11;
    rda_valid = 1'b1; rda_addr = 8'h12; #1;
    chk("pri_set_wr", wr_ready, 1);
    cycle();
    wr_valid = 1'b0; rda_rready = 1'b0; rdb_rready = 1'b0;
    rdb_valid = 1'b1; rdb_addr = 8'h05; #1;
    cycle();
    wr_valid = 1'b1; RST_N = 1'b0; #1;
    chk("mid_rst_rvalid", {rda_rvalid, rdb_rvalid}, 0);
    chk("mid_rst_rdata", {rda_rdata, rdb_rdata}, 0);
    chk("mid_rst_ram", {ram_EN0, ram_EN1, ram_WE0, ram_A0, ram_A1, ram_Di0}, 0);
    chk("mid_rst_readys", {wr_ready, rda_ready, rdb_ready}, 0);
    qa.delete(); qb.delete(); exp_rv_a = 1'b0; exp_rv_b = 1'b0;
    idle();
    @(negedge clk);
    RST_N = 1'b1;
    rda_rready = 1'b1; rdb_rready = 1'b1;
    wr_valid = 1'b1; wr_addr = 8'h41; wr_data = 16'h4141; wr_be = 2'b11;
    rda_valid = 1'b1; rda_addr = 8'h05; #1;
    chk("post_rst_wr_first", {wr_ready, rda_ready}, 2'b10);
    cycle();
    idle(); rda_valid = 1'b1; rda_addr = 8'h05; #1;
    cycle();
    idle(); #1;
    chk("post_rst_ram_kept", rda_rdata, 16'h5555);
    cycle();

    for (int n = 0; n < 10 && (qa.size() != 0 || qb.size() != 0); n++) begin
      idle(); #1; cycle();
    end
    chk("queues_drained", qa.size() + qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
